// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice.
// - FSM state encoding (IDLE/RUN/PAUSE/LAP), as shown on the debug LEDs.
// - BCD digit limit used by the counter chain.
// - Default debounce settings for a 100 MHz clock.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } sw_state_t;

  localparam logic [3:0]  BCD_MAX            = 4'd9;
  localparam int unsigned DEB_CYCLES_DEFAULT = 1000000;
  localparam int unsigned DEB_W_DEFAULT      = 20;

endpackage

// File: rtl/stopwatch_ctrl_btn_conditioner.sv
// Conditions one raw push-button and turns it into a press pulse.
// - Uses a 2-flop synchroniser, then a debounce counter.
// - Emits a one-clk pulse on each accepted 0->1 transition.
// - Releases produce no pulse, and holding the button produces a single pulse.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high; clears synchroniser, counter and level
//   raw   - asynchronous button input
//   pulse - one-clk press pulse, DEB_CYCLES+3 clk after a clean rising edge
module btn_conditioner
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int unsigned DEB_W      = DEB_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             level_d;   // previous synchronised level, for change detection
  logic             accepted;
  logic [DEB_W-1:0] cnt;
  logic             settled;

  assign settled = (cnt == DEB_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      level_d  <= 1'b0;
      accepted <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= sync2;
      if (sync2 != level_d) begin
        cnt <= '0;
      end else if (!settled) begin
        cnt <= cnt + DEB_W'(1);
      end
      if (settled) begin
        accepted <= level_d;
      end
    end
  end

  // The pulse spans the single cycle in which the settled level is 1
  // but has not yet been accepted.
  assign pulse = settled & level_d & ~accepted;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencing controller for the 4-digit BCD stopwatch.
// Ports:
//   clk, reset                                  - clock, synchronous active-high reset
//   start_btn, stop_btn, lap_btn, clear_btn     - raw asynchronous buttons
//   tick   - 1 kHz one-clk pulse from the divider
//   at_max - counter chain reads 9999
//   cen    - registered count enable for the units digit (1 clk after tick)
//   clr    - one-clk synchronous clear of the counter chain
//   freeze - display hold while in LAP (lags the state by one clk)
//   ovf    - sticky overflow flag
//   state  - current FSM state for debug LEDs
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int unsigned DEB_W      = DEB_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       lap_btn,
  input  logic       clear_btn,
  input  logic       tick,
  input  logic       at_max,
  output logic       cen,
  output logic       clr,
  output logic       freeze,
  output logic       ovf,
  output logic [1:0] state
);

  sw_state_t state_q;
  sw_state_t state_d;
  logic      ovf_d;
  logic      clr_d;
  logic      cen_d;

  logic start_p, stop_p, lap_p, clear_p;
  logic go_start, go_stop, go_lap, go_clear;
  logic running;
  logic ovf_hit;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_start (
    .clk(clk), .reset(reset), .raw(start_btn), .pulse(start_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_stop (
    .clk(clk), .reset(reset), .raw(stop_btn), .pulse(stop_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_lap (
    .clk(clk), .reset(reset), .raw(lap_btn), .pulse(lap_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_clear (
    .clk(clk), .reset(reset), .raw(clear_btn), .pulse(clear_p)
  );

  // Only the highest-priority press is acted on: clear > stop > lap > start.
  assign go_clear = clear_p;
  assign go_stop  = stop_p  & ~clear_p;
  assign go_lap   = lap_p   & ~clear_p & ~stop_p;
  assign go_start = start_p & ~clear_p & ~stop_p & ~lap_p;

  assign running = (state_q == RUN) || (state_q == LAP);
  assign ovf_hit = running & tick & at_max;
  assign cen_d   = running & tick & ~at_max;

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf;
    clr_d   = 1'b0;
    // Overflow takes precedence over any press in the same cycle, so the
    // count holds at 9999 instead of wrapping.
    if (ovf_hit) begin
      state_d = PAUSE;
      ovf_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go_start) state_d = RUN;
        end
        RUN: begin
          if (go_stop)     state_d = PAUSE;
          else if (go_lap) state_d = LAP;
        end
        LAP: begin
          if (go_lap)       state_d = RUN;
          else if (go_stop) state_d = PAUSE;
        end
        PAUSE: begin
          if (go_clear) begin
            state_d = IDLE;
            clr_d   = 1'b1;
            ovf_d   = 1'b0;
          end else if (go_start && !ovf) begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cen     <= 1'b0;
      clr     <= 1'b1;
      freeze  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      cen     <= cen_d;
      clr     <= clr_d;
      freeze  <= (state_q == LAP);
      ovf     <= ovf_d;
    end
  end

  assign state = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the 4-digit BCD stopwatch datapath: the 1 kHz tick source, the chain of four decimal counters, and the 7-segment display driver.
- Conditions the raw push-buttons and runs the run/pause/lap/clear state machine.
- Outputs:
  - cen: a single-cycle count-enable for the units digit.
  - clr: a synchronous clear for the counter chain.
  - freeze: a hold strobe that latches the display value during lap/split.
- Sits between the board buttons and the counter chain; replaces gating cen combinationally with the raw divider output.

Parameters:
- DEB_CYCLES, 1000000: consecutive stable cycles a synchronised button level must hold before it is accepted (10 ms at 100 MHz).
- DEB_W, 20: width of each debounce counter; must satisfy 2**DEB_W > DEB_CYCLES.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- start_btn  in  1  raw, asynchronous start button
- stop_btn  in  1  raw, asynchronous stop button
- lap_btn  in  1  raw, asynchronous lap/split button
- clear_btn  in  1  raw, asynchronous clear button
- tick  in  1  one-clk-wide pulse at 1 kHz from the clock divider
- at_max  in  1  high while the counter chain reads 9999 (AND of all four digit carries)
- cen  out  1  count enable to the units counter; at most one clk wide
- clr  out  1  one-clk synchronous clear to all four counters
- freeze  out  1  high = display holds its last latched value
- ovf  out  1  sticky overflow flag
- state  out  2  current FSM state, for debug LEDs

Behaviour:
- Reset: one clk, reset high, synchronous and active-high.
  - Next edge gives state=IDLE, cen=0, clr=1 (a single cycle of clr, asserted out of reset), freeze=0, ovf=0.
  - All synchronisers and debounce counters are cleared.
  - Reset mid-operation behaves identically.
- Button conditioning (per button):
  - 2-flop synchroniser.
  - Debounce counter resets on any change of the synchronised level, increments while the level is stable, and saturates at DEB_CYCLES.
  - Accepted level updates when the count reaches DEB_CYCLES.
  - A press pulse (1 clk) fires on an accepted 0->1 transition.
  - Latency: a clean press produces its pulse DEB_CYCLES+3 clk after the raw input rises.
  - Releases produce no pulse.
  - Holding a button produces exactly one pulse.
- Pulse priority when several press pulses fire in the same cycle: clear > stop > lap > start. Only the highest-priority pulse is acted on; the others are dropped.
- States:
  - IDLE=2'b00
  - RUN=2'b01
  - PAUSE=2'b10
  - LAP=2'b11
- Transitions (evaluated on press pulses):
  - IDLE: start -> RUN. All other buttons are ignored.
  - RUN: stop -> PAUSE; lap -> LAP; clear ignored.
  - LAP: lap -> RUN (freeze releases); stop -> PAUSE (freeze releases); clear ignored.
  - PAUSE: start -> RUN; clear -> IDLE with clr=1 for one cycle and ovf cleared; lap ignored.
- cen = tick AND (state is RUN or LAP) AND NOT at_max. It is registered, so it appears 1 clk after tick.
- freeze:
  - Registered; goes high the cycle after entering LAP and low the cycle after leaving it.
  - The counters keep running while freeze is high.
- Overflow:
  - In RUN or LAP, tick with at_max=1 forces state=PAUSE, sets ovf=1, and suppresses cen, so the count holds at 9999 with no wrap to 0000.
  - From PAUSE with ovf=1, start is ignored; only clear leaves this condition.
- A tick in the same cycle as a state-changing press is evaluated against the pre-transition state.
- State and all outputs change only on rising clk.

Decomposition:
- Shared package holds:
  - state encodings IDLE/RUN/PAUSE/LAP (2-bit localparams, matching the existing STOP/START/INC style);
  - BCD_MAX = 4'd9;
  - DEB_CYCLES default.
- Natural sub-module: btn_conditioner (synchroniser + debounce + rise-pulse).
  - Parameters: DEB_CYCLES, DEB_W.
  - Ports: clk, reset, raw, pulse.
  - Instantiated four times.
- FSM, cen and overflow logic stay in stopwatch_ctrl.

Test Plan (DEB_CYCLES=4):
- Reset, then idle 10 clk -> state=00, clr high for exactly 1 cycle after reset, cen=0, freeze=0, ovf=0.
- start_btn high at cycle 0 and held -> one internal pulse at cycle 7; state=01 at cycle 8. With ticks at 0..9 thereafter -> cen pulses 1 clk after each tick.
- start_btn bouncing 1-0-1-0-1 with 2-cycle gaps, then stable -> exactly one state change. Bouncing shorter than 4 cycles only -> no change.
- In RUN, lap press -> state=11, freeze=1, cen continues on ticks. Lap again -> state=01, freeze=0. Stop -> state=10, cen=0 on subsequent ticks.
- In PAUSE, start and clear pressed in the same cycle -> clear wins: state=00, clr=1 for one cycle.
- In RUN with at_max=1, tick -> state=10, ovf=1, no cen. Start press -> stays 10. Clear -> state=00, ovf=0, clr pulse.
